comp_serial_ctrl: RTL
=====================

// Module: comp_serial_ctrl
// PURPOSE
//   Sequences an external 2-bit magnitude comparator (G/L/E slice) to compare
//   two WIDTH-bit operands, 2 bits per cycle, MSB slice first.
//   Latches the operands on start, then drives one slice per cycle into the
//   comparator and samples its G/L/E outputs.
//   Reports gt/lt/eq plus an error flag with a start/busy/done handshake.
//   Sits between a requesting datapath and one shared comp_2bit instance.
// PARAMETERS
//   WIDTH   8   operand width; must be even and >= 2; SLICES = WIDTH/2.
//               An odd WIDTH is a compile-time error.
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request; accepted only in IDLE or DONE
//   a        in   WIDTH  operand A; sampled on the accepting edge
//   b        in   WIDTH  operand B; sampled on the accepting edge
//   busy     out  1      high while in RUN
//   done     out  1      one-cycle pulse; results valid in the same cycle
//   gt       out  1      A > B
//   lt       out  1      A < B
//   eq       out  1      A == B
//   err      out  1      comparator protocol fault seen during this compare
//   cmp_p    out  2      A slice to the comparator P input
//   cmp_q    out  2      B slice to the comparator Q input
//   cmp_g    in   1      comparator G output
//   cmp_l    in   1      comparator L output
//   cmp_e    in   1      comparator E output
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, gt, lt, eq, err=0; cmp_p=cmp_q=2'b00;
//     slice index=SLICES-1.
//   Reset asserted mid-RUN aborts the compare immediately; no done pulse.
//   FSM: IDLE -start-> RUN; RUN -last slice or decision (see macro)-> DONE;
//     DONE -> IDLE, or DONE -start-> RUN (back-to-back).
//   Accept (edge E0): latch a/b into shadow registers; idx=SLICES-1;
//     clear gt/lt/eq/err.
//   start is ignored while in RUN. Input a/b changes after E0 have no effect.
//   RUN: cmp_p/cmp_q = shadow[2*idx+1:2*idx], driven from registers/idx only.
//     The comparator is combinational; its outputs are sampled on the next edge.
//   Per sampled slice:
//     - Not exactly one of g/l/e high -> set err (sticky for this compare).
//     - g or l with no prior decision -> record decision.
//     - e -> no change.
//     - idx decrements toward 0.
//   Completion, written on entry to DONE:
//     - err=1 -> gt=lt=eq=0.
//     - otherwise decision g -> gt=1, l -> lt=1, none -> eq=1.
//     - Exactly one of gt/lt/eq/err is high at done.
//   done=1 only in the DONE cycle. gt/lt/eq/err hold until the next accept.
//   IDLE/DONE: cmp_p=cmp_q=2'b00.
//   Latency without macro: done is high in the cycle after edge E0+SLICES,
//     independent of the data.
// CONFIGURATION
//   COMP_EARLY_EXIT_EN defined:
//     - RUN exits to DONE on the edge that samples the first g or l (no error).
//     - Decided at MSB slice k (k=0 is MSB): done after E0+k+1.
//     - Equal operands still take SLICES cycles.
//     - A fault after the decision point is not observed.
//   COMP_EARLY_EXIT_EN undefined:
//     - Always scans all SLICES.
//     - First decision wins; later slices are only fault-checked.
// TESTING (WIDTH=8, SLICES=4, comp_2bit instance in the bench)
//   1. a=8'hA5, b=8'hA5, start 1 cycle -> busy 4 cycles; done@E0+4; eq=1, gt=lt=err=0.
//   2. a=8'hC0, b=8'h3F -> gt=1. With macro: done@E0+1. Without macro: done@E0+4.
//   3. a=8'h12, b=8'h13 -> lt=1, decided at LSB slice; done@E0+4 in both builds.
//   4. start held high through RUN, b changed mid-run -> first result unaffected;
//      restart accepted in the DONE cycle; second result correct; no lost done.
//   5. Force cmp_g=cmp_l=1 at slice 2 (no macro) -> err=1, gt=lt=eq=0 at done.
//   6. Drop rst_n at E0+2 -> all outputs 0 at once, no done; next start works normally.

Source files
------------

// File: rtl/comp_serial_ctrl.sv
// Serial WIDTH-bit magnitude compare driven through an external 2-bit G/L/E comparator, MSB slice first.
// Optional macro COMP_EARLY_EXIT_EN: finish as soon as the first valid G or L slice is sampled.
module comp_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             err,
  output logic [1:0]       cmp_p,
  output logic [1:0]       cmp_q,
  input  logic             cmp_g,
  input  logic             cmp_l,
  input  logic             cmp_e
);
  localparam int SLICES = WIDTH / 2;
  localparam int IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_check
      $error("comp_serial_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, a_sh_next, b_sh, b_sh_next;
  logic [IDXW-1:0]  idx, idx_next;
  logic             dec_g, dec_g_next, dec_l, dec_l_next;
  logic             err_acc, err_acc_next;
  logic             gt_next, lt_next, eq_next, err_next;
  logic             sample_ok, finish;

  logic [1:0] a_sl [SLICES];
  logic [1:0] b_sl [SLICES];

  for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
    assign a_sl[gi] = a_sh[2*gi +: 2];
    assign b_sl[gi] = b_sh[2*gi +: 2];
  end

  // Comparator inputs come only from the shadow registers and the slice index.
  assign cmp_p = (state == RUN) ? a_sl[idx] : 2'b00;
  assign cmp_q = (state == RUN) ? b_sl[idx] : 2'b00;
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  assign sample_ok = ({cmp_g, cmp_l, cmp_e} == 3'b100) ||
                     ({cmp_g, cmp_l, cmp_e} == 3'b010) ||
                     ({cmp_g, cmp_l, cmp_e} == 3'b001);

  always_comb begin
    state_next   = state;
    a_sh_next    = a_sh;
    b_sh_next    = b_sh;
    idx_next     = idx;
    dec_g_next   = dec_g;
    dec_l_next   = dec_l;
    err_acc_next = err_acc;
    gt_next      = gt;
    lt_next      = lt;
    eq_next      = eq;
    err_next     = err;
    finish       = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          state_next   = RUN;
          a_sh_next    = a;
          b_sh_next    = b;
          idx_next     = LAST_IDX;
          dec_g_next   = 1'b0;
          dec_l_next   = 1'b0;
          err_acc_next = 1'b0;
          gt_next      = 1'b0;
          lt_next      = 1'b0;
          eq_next      = 1'b0;
          err_next     = 1'b0;
        end
      end
      RUN: begin
        if (!sample_ok) err_acc_next = 1'b1;
        // First valid G or L wins; later slices are only fault-checked.
        if (sample_ok && !dec_g && !dec_l) begin
          dec_g_next = cmp_g;
          dec_l_next = cmp_l;
        end
`ifdef COMP_EARLY_EXIT_EN
        finish = (idx == '0) || (sample_ok && (cmp_g || cmp_l));
`else
        finish = (idx == '0);
`endif
        if (finish) begin
          state_next = DONE;
          gt_next    = !err_acc_next && dec_g_next;
          lt_next    = !err_acc_next && dec_l_next;
          eq_next    = !err_acc_next && !dec_g_next && !dec_l_next;
          err_next   = err_acc_next;
        end else begin
          idx_next = idx - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      idx     <= LAST_IDX;
      dec_g   <= 1'b0;
      dec_l   <= 1'b0;
      err_acc <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      a_sh    <= a_sh_next;
      b_sh    <= b_sh_next;
      idx     <= idx_next;
      dec_g   <= dec_g_next;
      dec_l   <= dec_l_next;
      err_acc <= err_acc_next;
      gt      <= gt_next;
      lt      <= lt_next;
      eq      <= eq_next;
      err     <= err_next;
    end
  end
endmodule
